decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I(+M) instruction decode pipeline stage. It decodes a fetched 32-bit instruction into
//  opcode/func3/func7, sign-extended immediate, register indices and an illegal flag. These are
//  the fields the execute-stage ALU consumes. Sits between fetch and execute, with a valid/ready
//  handshake on both sides and a 2-entry skid buffer so in_ready is driven from a register.
// PARAMETERS
//  ENABLE_M       1  1: func7=0000001 R-type (MUL..REMU) legal; 0: flagged illegal
//  ZERO_UNUSED_RS 1  1: rs1/rs2 outputs forced to 0 for formats that do not read them
// PORTS
//  clk          input   1   clock, rising edge
//  rst          input   1   asynchronous reset, active-high
//  flush        input   1   sync; discard all buffered and incoming instructions
//  in_valid     input   1   fetch presents instr/pc
//  in_ready     output  1   stage can accept (registered)
//  in_instr     input   32  raw instruction
//  in_pc        input   32  instruction address
//  out_valid    output  1   decoded entry valid
//  out_ready    input   1   execute accepts entry
//  out_opcode   output  7   instr[6:0]
//  out_func3    output  3   instr[14:12]; 0 for U/J
//  out_func7    output  7   instr[31:25] for R-type and shift-imm; else 0
//  out_imm      output  32  sign-extended immediate per format; 0 for R-type
//  out_rs1/out_rs2/out_rd  output  5 each  register indices
//  out_pc       output  32  pc of the entry
//  out_reg_wr   output  1   instruction writes rd (rd!=0)
//  out_illegal  output  1   unsupported/malformed encoding
// BEHAVIOUR
//  - Reset (async): both buffer entries empty; out_valid=0; in_ready=1; all data outputs 0.
//  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
//  - Latency: an accepted instr appears on outputs the next cycle when the stage was empty.
//  - Decode happens at input (combinational); buffers store decoded fields. Outputs come from
//    the head entry and stay stable while out_valid&!out_ready.
//  - Occupancy states EMPTY(0), ONE(1), FULL(2):
//    EMPTY-in->ONE; ONE-in&!out->FULL; ONE-!in&out->EMPTY; ONE in&out->ONE; FULL-out->ONE.
//  - in_ready=(occupancy<2), registered. In FULL, in_valid is ignored. No drops, strict FIFO order.
//  - flush: highest priority. Next cycle occupancy=0, out_valid=0, in_ready=1. A same-cycle
//    input is discarded; a same-cycle out handshake still counts downstream.
//  - Formats by opcode: R 0110011; I 0010011/0000011/1100111/1110011; S 0100011;
//    B 1100011; U 0110111/0010111; J 1101111.
//  - Immediates: I {{20{i[31]}},i[31:20]}; S {{20{i[31]}},i[31:25],i[11:7]};
//    B {{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}; U {i[31:12],12'b0};
//    J {{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}.
//  - Shift-imm (func3 001/101, opcode 0010011): imm=instr[24:20] zero-extended;
//    func7=instr[31:25].
//  - Illegal cases:
//    - instr[1:0]!=2'b11, or an unlisted opcode.
//    - R-type func7 not in {0000000, 0100000, 0000001 (ENABLE_M only)}.
//    - func7=0100000 with func3 not 000/101.
//    - SLLI with func7!=0, or SRLI/SRAI with func7 not 0000000/0100000.
//    - JALR with func3!=0.
//  - Illegal entries still flow through; out_reg_wr=0 on them.
//  - out_reg_wr=0 for S/B formats and for rd==0.
// TESTING
//  - 0xFFF00093 (addi x1,x0,-1) -> opcode 0010011, rd 1, rs1 0, func3 0, imm 0xFFFFFFFF,
//    reg_wr 1, 1-cycle latency.
//  - 0x0020A423 (sw x2,8(x1)) -> imm 8, rs1 1, rs2 2, reg_wr 0.
//    0xFE000EE3 (beq -4) -> imm 0xFFFFFFFC.
//    0x123450B7 (lui) -> imm 0x12345000, rd 1.
//  - 0x022081B3 (mul x3,x1,x2) -> func7 0000001, illegal 0 with ENABLE_M=1, illegal 1 with
//    ENABLE_M=0; 0x00000000 -> illegal 1.
//  - out_ready=0, offer A,B,C back-to-back -> A,B accepted, in_ready low, out holds A.
//    Release -> A,B,C delivered in order, no loss.
//  - FULL, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing of the
//    flushed or offered instrs emerges.
//  - Assert rst mid-stream, async -> out_valid=0 immediately, in_ready=1 after release.

Source files
------------

// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
//  Module  : decode_stage_if
//  Brief   : Fetch-side and execute-side handshake bundle for decode_stage.
//            The master modport is the environment (fetch + execute + flush).
//            The slave modport is the decode stage itself.
//  Revision: 1.0 - initial release
// ============================================================================
interface decode_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [2:0]  out_func3;
    logic [6:0]  out_func7;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_pc;
    logic        out_reg_wr;
    logic        out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_func3, out_func7, out_imm,
               out_rs1, out_rs2, out_rd, out_pc, out_reg_wr, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_func3, out_func7, out_imm,
               out_rs1, out_rs2, out_rd, out_pc, out_reg_wr, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module  : decode_stage
//  Brief   : RV32I(+M) decode pipeline stage. Decodes combinationally at the
//            input and stores decoded entries in a 2-entry skid buffer so that
//            in_ready comes straight from a flop.
//  Revision: 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter bit ENABLE_M       = 1'b1,
    parameter bit ZERO_UNUSED_RS = 1'b1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    decode_stage_if.slave bus
);

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        reg_wr;
        logic        illegal;
    } entry_t;

    // Occupancy states of the skid buffer
    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_FULL  = 2'd2;

    // Opcodes
    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // Instruction formats
    localparam logic [2:0] c_FMT_R = 3'd0;
    localparam logic [2:0] c_FMT_I = 3'd1;
    localparam logic [2:0] c_FMT_S = 3'd2;
    localparam logic [2:0] c_FMT_B = 3'd3;
    localparam logic [2:0] c_FMT_U = 3'd4;
    localparam logic [2:0] c_FMT_J = 3'd5;
    localparam logic [2:0] c_FMT_X = 3'd6;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MUL  = 7'b0000001;

    logic [31:0] w_instr;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [2:0]  w_fmt;
    logic        w_shift;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_ill;
    entry_t      w_dec;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    entry_t      r_e0;
    entry_t      r_e1;
    entry_t      w_e0_nxt;
    entry_t      w_e1_nxt;
    logic        r_in_ready;
    logic        w_push;
    logic        w_pop;

    assign w_instr = bus.in_instr;
    assign w_op    = w_instr[6:0];
    assign w_f3    = w_instr[14:12];
    assign w_f7    = w_instr[31:25];
    assign w_shift = (w_op == c_OP_IMM) && ((w_f3 == 3'b001) || (w_f3 == 3'b101));

    // Classify the opcode into an encoding format; unlisted opcodes (including
    // anything with instr[1:0] != 2'b11) fall into the illegal class.
    always_comb begin
        w_fmt = c_FMT_X;
        case (w_op)
            c_OP_R:                                       w_fmt = c_FMT_R;
            c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM:  w_fmt = c_FMT_I;
            c_OP_STORE:                                   w_fmt = c_FMT_S;
            c_OP_BRANCH:                                  w_fmt = c_FMT_B;
            c_OP_LUI, c_OP_AUIPC:                         w_fmt = c_FMT_U;
            c_OP_JAL:                                     w_fmt = c_FMT_J;
            default:                                      w_fmt = c_FMT_X;
        endcase
    end

    // Field extraction, immediate generation and legality check
    always_comb begin
        w_dec     = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_ill     = 1'b0;
        w_dec.opcode = w_op;
        w_dec.pc     = bus.in_pc;
        case (w_fmt)
            c_FMT_R: begin
                w_dec.func3 = w_f3;
                w_dec.func7 = w_f7;
                w_dec.rd    = w_instr[11:7];
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
                if (!((w_f7 == c_F7_BASE) || (w_f7 == c_F7_ALT) ||
                      (ENABLE_M && (w_f7 == c_F7_MUL))))
                    w_ill = 1'b1;
                if ((w_f7 == c_F7_ALT) && (w_f3 != 3'b000) && (w_f3 != 3'b101))
                    w_ill = 1'b1;
            end
            c_FMT_I: begin
                w_dec.func3 = w_f3;
                w_dec.rd    = w_instr[11:7];
                w_use_rs1   = 1'b1;
                if (w_shift) begin
                    w_dec.func7 = w_f7;
                    w_dec.imm   = {27'b0, w_instr[24:20]};
                    if ((w_f3 == 3'b001) && (w_f7 != c_F7_BASE))
                        w_ill = 1'b1;
                    if ((w_f3 == 3'b101) && (w_f7 != c_F7_BASE) && (w_f7 != c_F7_ALT))
                        w_ill = 1'b1;
                end else begin
                    w_dec.imm = {{20{w_instr[31]}}, w_instr[31:20]};
                end
                if ((w_op == c_OP_JALR) && (w_f3 != 3'b000))
                    w_ill = 1'b1;
            end
            c_FMT_S: begin
                w_dec.func3 = w_f3;
                w_dec.imm   = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            c_FMT_B: begin
                w_dec.func3 = w_f3;
                w_dec.imm   = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                               w_instr[30:25], w_instr[11:8], 1'b0};
                w_use_rs1   = 1'b1;
                w_use_rs2   = 1'b1;
            end
            c_FMT_U: begin
                w_dec.rd  = w_instr[11:7];
                w_dec.imm = {w_instr[31:12], 12'b0};
            end
            c_FMT_J: begin
                w_dec.rd  = w_instr[11:7];
                w_dec.imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                             w_instr[20], w_instr[30:21], 1'b0};
            end
            default: begin
                w_dec.func3 = w_f3;
                w_ill       = 1'b1;
            end
        endcase
        w_dec.rs1     = (w_use_rs1 || !ZERO_UNUSED_RS) ? w_instr[19:15] : 5'd0;
        w_dec.rs2     = (w_use_rs2 || !ZERO_UNUSED_RS) ? w_instr[24:20] : 5'd0;
        w_dec.illegal = w_ill;
        // rd is only populated for formats that write a register
        w_dec.reg_wr  = !w_ill && (w_dec.rd != 5'd0);
    end

    // Flush discards the incoming instruction; a downstream pop still counts
    assign w_push = bus.in_valid && r_in_ready && !bus.flush;
    assign w_pop  = (r_state != c_ST_EMPTY) && bus.out_ready;

    // Occupancy next-state and entry movement (head entry is always r_e0)
    always_comb begin
        w_state_nxt = r_state;
        w_e0_nxt    = r_e0;
        w_e1_nxt    = r_e1;
        case (r_state)
            c_ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = c_ST_ONE;
                    w_e0_nxt    = w_dec;
                end
            end
            c_ST_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = c_ST_FULL;
                    w_e1_nxt    = w_dec;
                end else if (w_push && w_pop) begin
                    w_e0_nxt    = w_dec;
                end else if (w_pop) begin
                    w_state_nxt = c_ST_EMPTY;
                end
            end
            c_ST_FULL: begin
                if (w_pop) begin
                    w_state_nxt = c_ST_ONE;
                    w_e0_nxt    = r_e1;
                end
            end
            default: w_state_nxt = c_ST_EMPTY;
        endcase
        if (bus.flush)
            w_state_nxt = c_ST_EMPTY;
    end

    // State, buffer entries and registered in_ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_EMPTY;
            r_e0       <= '0;
            r_e1       <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_e0       <= w_e0_nxt;
            r_e1       <= w_e1_nxt;
            r_in_ready <= (w_state_nxt != c_ST_FULL);
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = (r_state != c_ST_EMPTY);
    assign bus.out_opcode  = r_e0.opcode;
    assign bus.out_func3   = r_e0.func3;
    assign bus.out_func7   = r_e0.func7;
    assign bus.out_imm     = r_e0.imm;
    assign bus.out_rs1     = r_e0.rs1;
    assign bus.out_rs2     = r_e0.rs2;
    assign bus.out_rd      = r_e0.rd;
    assign bus.out_pc      = r_e0.pc;
    assign bus.out_reg_wr  = r_e0.reg_wr;
    assign bus.out_illegal = r_e0.illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_decode_stage
//  Brief   : Directed self-checking bench for decode_stage (ENABLE_M=1 and a
//            second ENABLE_M=0 instance sharing the same stimulus).
//  Revision: 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    decode_stage_if bus();
    decode_stage_if bus_nm();

    assign bus_nm.flush     = bus.flush;
    assign bus_nm.in_valid  = bus.in_valid;
    assign bus_nm.in_instr  = bus.in_instr;
    assign bus_nm.in_pc     = bus.in_pc;
    assign bus_nm.out_ready = bus.out_ready;

    decode_stage #(.ENABLE_M(1'b1), .ZERO_UNUSED_RS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    decode_stage #(.ENABLE_M(1'b0), .ZERO_UNUSED_RS(1'b1)) dut_nm (
        .clk (clk),
        .rst (rst),
        .bus (bus_nm)
    );

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        chk_fld;
        logic        chk_rd;
        logic        wr;
        logic        ill;
        logic        ill_nm;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.in_pc     = 32'h0;
        bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_imm !== 32'h0) begin errors++; $display("FAIL reset_imm got %h exp 0", bus.out_imm); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus.out_pc); end
        checks++; if (bus.out_opcode !== 7'h0) begin errors++; $display("FAIL reset_opcode got %h exp 0", bus.out_opcode); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_decode();
        logic [31:0] pc;
        vecs[0]  = '{32'hFFF00093, 7'h13, 3'd0, 7'h00, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h0020A423, 7'h23, 3'd2, 7'h00, 32'h00000008, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 7'h63, 3'd0, 7'h00, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h123450B7, 7'h37, 3'd0, 7'h00, 32'h12345000, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{32'h022081B3, 7'h33, 3'd0, 7'h01, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{32'h00000000, 7'h00, 3'd0, 7'h00, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{32'h40315093, 7'h13, 3'd5, 7'h20, 32'h00000003, 5'd2, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h40311093, 7'h13, 3'd1, 7'h20, 32'h00000003, 5'd2, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{32'h000090E7, 7'h67, 3'd1, 7'h00, 32'h00000000, 5'd1, 5'd0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{32'h402091B3, 7'h33, 3'd1, 7'h20, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{32'h800000EF, 7'h6F, 3'd0, 7'h00, 32'hFFF00000, 5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h00208033, 7'h33, 3'd0, 7'h00, 32'h00000000, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'hFFF00092, 7'h12, 3'd0, 7'h00, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            pc           = 32'h1000 + 32'(i * 4);
            bus.in_valid = 1'b1;
            bus.in_instr = vecs[i].instr;
            bus.in_pc    = pc;
            step();
            bus.in_valid = 1'b0;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d_latency out_valid got %b exp 1", i, bus.out_valid); end
            checks++; if (bus.out_pc !== pc) begin errors++; $display("FAIL dec%0d_pc got %h exp %h", i, bus.out_pc, pc); end
            checks++; if (bus.out_opcode !== vecs[i].op) begin errors++; $display("FAIL dec%0d_opcode got %h exp %h", i, bus.out_opcode, vecs[i].op); end
            checks++; if (bus.out_illegal !== vecs[i].ill) begin errors++; $display("FAIL dec%0d_illegal got %b exp %b", i, bus.out_illegal, vecs[i].ill); end
            checks++; if (bus_nm.out_illegal !== vecs[i].ill_nm) begin errors++; $display("FAIL dec%0d_illegal_nom got %b exp %b", i, bus_nm.out_illegal, vecs[i].ill_nm); end
            checks++; if (bus.out_reg_wr !== vecs[i].wr) begin errors++; $display("FAIL dec%0d_reg_wr got %b exp %b", i, bus.out_reg_wr, vecs[i].wr); end
            if (vecs[i].chk_fld) begin
                checks++; if (bus.out_func3 !== vecs[i].f3) begin errors++; $display("FAIL dec%0d_func3 got %h exp %h", i, bus.out_func3, vecs[i].f3); end
                checks++; if (bus.out_func7 !== vecs[i].f7) begin errors++; $display("FAIL dec%0d_func7 got %h exp %h", i, bus.out_func7, vecs[i].f7); end
                checks++; if (bus.out_imm !== vecs[i].imm) begin errors++; $display("FAIL dec%0d_imm got %h exp %h", i, bus.out_imm, vecs[i].imm); end
                checks++; if (bus.out_rs1 !== vecs[i].rs1) begin errors++; $display("FAIL dec%0d_rs1 got %0d exp %0d", i, bus.out_rs1, vecs[i].rs1); end
                checks++; if (bus.out_rs2 !== vecs[i].rs2) begin errors++; $display("FAIL dec%0d_rs2 got %0d exp %0d", i, bus.out_rs2, vecs[i].rs2); end
            end
            if (vecs[i].chk_rd) begin
                checks++; if (bus.out_rd !== vecs[i].rd) begin errors++; $display("FAIL dec%0d_rd got %0d exp %0d", i, bus.out_rd, vecs[i].rd); end
            end
        end
        // Drain the last entry
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain out_valid got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got_pc  [$];
        logic [31:0] got_imm [$];
        logic        fire_in;
        logic        fire_out;
        int          sent;
        bus.out_ready = 1'b0;
        // A
        bus.in_valid = 1'b1; bus.in_instr = 32'h00100093; bus.in_pc = 32'h200;
        step();
        // B
        bus.in_instr = 32'h00200093; bus.in_pc = 32'h204;
        step();
        // C offered while full
        bus.in_instr = 32'h00300093; bus.in_pc = 32'h208;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b exp 0", bus.in_ready); end
        step();
        step();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_in_ready got %b exp 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_out_valid got %b exp 1", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'h200) begin errors++; $display("FAIL b2b_hold_pc got %h exp 00000200", bus.out_pc); end
        checks++; if (bus.out_imm !== 32'h1) begin errors++; $display("FAIL b2b_hold_imm got %h exp 00000001", bus.out_imm); end
        bus.out_ready = 1'b1;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                got_pc.push_back(bus.out_pc);
                got_imm.push_back(bus.out_imm);
            end
            step();
            if (fire_in) begin
                bus.in_valid = 1'b0;
                sent++;
            end
        end
        checks++; if (sent !== 1) begin errors++; $display("FAIL b2b_c_accepted got %0d exp 1", sent); end
        checks++; if (got_pc.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", got_pc.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < got_pc.size()) begin
                checks++; if (got_pc[k] !== 32'h200 + 32'(k * 4)) begin errors++; $display("FAIL b2b_order%0d_pc got %h exp %h", k, got_pc[k], 32'h200 + 32'(k * 4)); end
                checks++; if (got_imm[k] !== 32'(k + 1)) begin errors++; $display("FAIL b2b_order%0d_imm got %h exp %h", k, got_imm[k], 32'(k + 1)); end
            end
        end
    endtask

    task automatic test_flush();
        logic seen;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_instr = 32'h00500093; bus.in_pc = 32'h300;
        step();
        bus.in_instr = 32'h00600093; bus.in_pc = 32'h304;
        step();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull in_ready got %b exp 0", bus.in_ready); end
        bus.flush    = 1'b1;
        bus.in_instr = 32'h00700093; bus.in_pc = 32'h308;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b exp 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_leak out_valid_seen got %b exp 0", seen); end
        // Stage works normally after a flush
        bus.in_valid = 1'b1; bus.in_instr = 32'h00800093; bus.in_pc = 32'h30C;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_pc !== 32'h30C) begin errors++; $display("FAIL flush_resume_pc got %h exp 0000030c", bus.out_pc); end
        step();
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_instr = 32'h00900093; bus.in_pc = 32'h400;
        step();
        bus.in_instr = 32'h00A00093; bus.in_pc = 32'h404;
        step();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre out_valid got %b exp 1", bus.out_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_immediate out_valid got %b exp 0", bus.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_release in_ready got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_release out_valid got %b exp 0", bus.out_valid); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
